// File: rtl/matmul_sched_pkg.sv
// Shared types and constants for the systolic matmul block scheduler.
// The descriptor struct is sized from the default scheduler widths below.
package matmul_sched_pkg;

    localparam int SCHED_N1   = 4;
    localparam int SCHED_N2   = 4;
    localparam int LOG2_N1    = $clog2(SCHED_N1);
    localparam int LOG2_N2    = $clog2(SCHED_N2);
    localparam int DESC_MS_W  = 16;
    localparam int DESC_BLK_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_CFG   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_NEXT  = 3'd5,
        ST_FIN   = 3'd6
    } sched_state_t;

    typedef struct packed {
        logic [DESC_MS_W-1:0]  m1;
        logic [DESC_MS_W-1:0]  m2;
        logic [DESC_MS_W-1:0]  block_width;
        logic [DESC_BLK_W-1:0] num_blocks;
    } desc_t;

endpackage

// File: rtl/matmul_desc_check.sv
// Combinational descriptor validation and derivation of the read-controller
// configuration words from a latched job descriptor.
module matmul_desc_check
    import matmul_sched_pkg::*;
#(
    parameter int L2_N1        = LOG2_N1,
    parameter int L2_N2        = LOG2_N2,
    parameter int MATRIXSIZE_W = DESC_MS_W,
    parameter int ADDR_W_B     = 12,
    parameter int BLK_W        = DESC_BLK_W
) (
    input  desc_t                   desc,
    output logic [MATRIXSIZE_W-1:0] m1_dn1,
    output logic [MATRIXSIZE_W-1:0] bw_dn2,
    output logic [MATRIXSIZE_W-1:0] prod,
    output logic                    ok
);

    localparam int PROD_W = 2 * MATRIXSIZE_W;
    localparam int SPAN_W = BLK_W + MATRIXSIZE_W;
    localparam logic [MATRIXSIZE_W-1:0] N1_MASK = MATRIXSIZE_W'((1 << L2_N1) - 1);
    localparam logic [MATRIXSIZE_W-1:0] N2_MASK = MATRIXSIZE_W'((1 << L2_N2) - 1);

    logic [PROD_W-1:0] prod_wide;
    logic [SPAN_W-1:0] span;
    logic [BLK_W-1:0]  nb_minus1;
    logic [5:0]        reject;

    always_comb begin
        m1_dn1    = desc.m1 >> L2_N1;
        bw_dn2    = desc.block_width >> L2_N2;
        prod_wide = PROD_W'(m1_dn1) * PROD_W'(bw_dn2);
        prod      = prod_wide[MATRIXSIZE_W-1:0];
        // Offset of the last block; only meaningful when num_blocks != 0.
        nb_minus1 = desc.num_blocks - BLK_W'(1);
        span      = SPAN_W'(nb_minus1) * SPAN_W'(desc.block_width);

        reject[0] = (desc.num_blocks == '0) || (desc.m1 == '0) || (desc.block_width == '0);
        reject[1] = (desc.m2 < MATRIXSIZE_W'(2));
        reject[2] = (desc.m1 & N1_MASK) != '0;
        reject[3] = (desc.block_width & N2_MASK) != '0;
        reject[4] = prod_wide[PROD_W-1:MATRIXSIZE_W] != '0;
        reject[5] = (span >> ADDR_W_B) != '0;
        ok        = ~|reject;
    end

endmodule

// File: rtl/matmul_block_sched.sv
// Job sequencer for the N1xN2 systolic matmul: validates a descriptor, then
// runs the read controller once per column block and hands each block to drain.
module matmul_block_sched
    import matmul_sched_pkg::*;
#(
    parameter int N1           = SCHED_N1,
    parameter int N2           = SCHED_N2,
    parameter int MATRIXSIZE_W = DESC_MS_W,
    parameter int ADDR_W_B     = 12,
    parameter int BLK_W        = DESC_BLK_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [MATRIXSIZE_W-1:0] M1,
    input  logic [MATRIXSIZE_W-1:0] M2,
    input  logic [MATRIXSIZE_W-1:0] BLOCK_WIDTH,
    input  logic [BLK_W-1:0]        NUM_BLOCKS,
    input  logic                    done_read_control,
    input  logic                    drain_ack,
    output logic                    core_rst,
    output logic [MATRIXSIZE_W-1:0] M2_o,
    output logic [MATRIXSIZE_W-1:0] M1dN1,
    output logic [MATRIXSIZE_W-1:0] BLOCK_WIDTHdN2,
    output logic [MATRIXSIZE_W-1:0] M1xBLOCK_WIDTHdN1xN2,
    output logic [ADDR_W_B-1:0]     b_col_base,
    output logic [BLK_W-1:0]        block_idx,
    output logic                    drain_req,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    sched_state_t state_reg, state_next;
    desc_t        desc_reg, desc_next;

    logic [MATRIXSIZE_W-1:0] m2_reg, m2_next;
    logic [MATRIXSIZE_W-1:0] m1dn1_reg, m1dn1_next;
    logic [MATRIXSIZE_W-1:0] bwdn2_reg, bwdn2_next;
    logic [MATRIXSIZE_W-1:0] prod_reg, prod_next;
    logic [ADDR_W_B-1:0]     b_col_base_reg, b_col_base_next;
    logic [BLK_W-1:0]        block_idx_reg, block_idx_next;
    logic                    core_rst_reg, core_rst_next;
    logic                    drain_req_reg, drain_req_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    err_reg, err_next;

    logic [MATRIXSIZE_W-1:0] chk_m1_dn1;
    logic [MATRIXSIZE_W-1:0] chk_bw_dn2;
    logic [MATRIXSIZE_W-1:0] chk_prod;
    logic                    chk_ok;

    matmul_desc_check #(
        .L2_N1        ($clog2(N1)),
        .L2_N2        ($clog2(N2)),
        .MATRIXSIZE_W (MATRIXSIZE_W),
        .ADDR_W_B     (ADDR_W_B),
        .BLK_W        (BLK_W)
    ) u_desc_check (
        .desc   (desc_reg),
        .m1_dn1 (chk_m1_dn1),
        .bw_dn2 (chk_bw_dn2),
        .prod   (chk_prod),
        .ok     (chk_ok)
    );

    always_comb begin
        state_next      = state_reg;
        desc_next       = desc_reg;
        m2_next         = m2_reg;
        m1dn1_next      = m1dn1_reg;
        bwdn2_next      = bwdn2_reg;
        prod_next       = prod_reg;
        b_col_base_next = b_col_base_reg;
        block_idx_next  = block_idx_reg;
        err_next        = err_reg;

        // Abort wins over every other transition, including a same-cycle ack.
        if (abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        desc_next.m1          = M1;
                        desc_next.m2          = M2;
                        desc_next.block_width = BLOCK_WIDTH;
                        desc_next.num_blocks  = NUM_BLOCKS;
                        err_next              = 1'b0;
                        state_next            = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (chk_ok) begin
                        m2_next         = desc_reg.m2;
                        m1dn1_next      = chk_m1_dn1;
                        bwdn2_next      = chk_bw_dn2;
                        prod_next       = chk_prod;
                        block_idx_next  = '0;
                        b_col_base_next = '0;
                        state_next      = ST_CFG;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_CFG: state_next = ST_RUN;
                ST_RUN: begin
                    if (done_read_control) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_ack) begin
                        state_next = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (block_idx_reg == desc_reg.num_blocks - BLK_W'(1)) begin
                        state_next = ST_FIN;
                    end else begin
                        block_idx_next  = block_idx_reg + BLK_W'(1);
                        // Range of the last base address was checked up front.
                        b_col_base_next = b_col_base_reg + ADDR_W_B'(desc_reg.block_width);
                        state_next      = ST_CFG;
                    end
                end
                ST_FIN:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end

        // Handshake outputs are registered decodes of the state being entered.
        core_rst_next  = (state_next != ST_RUN);
        drain_req_next = (state_next == ST_DRAIN);
        busy_next      = (state_next != ST_IDLE);
        done_next      = (state_next == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            desc_reg       <= '0;
            m2_reg         <= '0;
            m1dn1_reg      <= '0;
            bwdn2_reg      <= '0;
            prod_reg       <= '0;
            b_col_base_reg <= '0;
            block_idx_reg  <= '0;
            core_rst_reg   <= 1'b1;
            drain_req_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            desc_reg       <= desc_next;
            m2_reg         <= m2_next;
            m1dn1_reg      <= m1dn1_next;
            bwdn2_reg      <= bwdn2_next;
            prod_reg       <= prod_next;
            b_col_base_reg <= b_col_base_next;
            block_idx_reg  <= block_idx_next;
            core_rst_reg   <= core_rst_next;
            drain_req_reg  <= drain_req_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    assign core_rst             = core_rst_reg;
    assign M2_o                 = m2_reg;
    assign M1dN1                = m1dn1_reg;
    assign BLOCK_WIDTHdN2       = bwdn2_reg;
    assign M1xBLOCK_WIDTHdN1xN2 = prod_reg;
    assign b_col_base           = b_col_base_reg;
    assign block_idx            = block_idx_reg;
    assign drain_req            = drain_req_reg;
    assign busy                 = busy_reg;
    assign done                 = done_reg;
    assign err                  = err_reg;

endmodule

// File: tb/tb_matmul_block_sched.sv
// Directed self-checking bench for matmul_block_sched (N1=N2=4 defaults).
module tb_matmul_block_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] m1;
    logic [15:0] m2;
    logic [15:0] bw;
    logic [7:0]  nb;
    logic        drc;
    logic        ack;
    logic        core_rst;
    logic [15:0] M2_o;
    logic [15:0] M1dN1;
    logic [15:0] BLOCK_WIDTHdN2;
    logic [15:0] M1xBLOCK_WIDTHdN1xN2;
    logic [11:0] b_col_base;
    logic [7:0]  block_idx;
    logic        drain_req;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int done_count = 0;

    // {core_rst, busy, drain_req, done, err}
    logic [4:0] flags;
    assign flags = {core_rst, busy, drain_req, done, err};

    int tab_m1  [9] = '{8, 0, 8, 8, 8, 1024, 1020, 8, 8};
    int tab_m2  [9] = '{16, 16, 1, 2, 16, 16, 16, 16, 16};
    int tab_bw  [9] = '{8, 8, 8, 8, 6, 1024, 1024, 2048, 2048};
    int tab_nb  [9] = '{0, 1, 1, 1, 1, 1, 1, 3, 2};
    bit tab_rej [9] = '{1, 1, 1, 0, 1, 1, 0, 1, 0};

    matmul_block_sched dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .abort                (abort),
        .M1                   (m1),
        .M2                   (m2),
        .BLOCK_WIDTH          (bw),
        .NUM_BLOCKS           (nb),
        .done_read_control    (drc),
        .drain_ack            (ack),
        .core_rst             (core_rst),
        .M2_o                 (M2_o),
        .M1dN1                (M1dN1),
        .BLOCK_WIDTHdN2       (BLOCK_WIDTHdN2),
        .M1xBLOCK_WIDTHdN1xN2 (M1xBLOCK_WIDTHdN1xN2),
        .b_col_base           (b_col_base),
        .block_idx            (block_idx),
        .drain_req            (drain_req),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in CHECK; descriptor inputs are scrambled afterwards.
    task automatic start_job(input int a, input int b, input int c, input int n);
        m1 = 16'(a); m2 = 16'(b); bw = 16'(c); nb = 8'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        m1 = 16'hFFFF; m2 = 16'h0001; bw = 16'h0003; nb = 8'h00;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++;
        if (flags !== 5'b10000) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", flags, 5'b10000);
        end
        checks++;
        if ({block_idx, b_col_base, M2_o, M1dN1, BLOCK_WIDTHdN2, M1xBLOCK_WIDTHdN1xN2} !== 84'd0) begin
            errors++; $display("FAIL reset_words: got idx=%0d base=%0d m2=%0d m1d=%0d bwd=%0d prod=%0d expected all 0",
                               block_idx, b_col_base, M2_o, M1dN1, BLOCK_WIDTHdN2, M1xBLOCK_WIDTHdN1xN2);
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (flags !== 5'b10000) begin
            errors++; $display("FAIL reset_release_flags: got %b expected %b", flags, 5'b10000);
        end
    endtask

    task automatic test_normal();
        int d0;
        d0 = done_count;
        start_job(8, 16, 8, 3);
        checks++;
        if (flags !== 5'b11000) begin
            errors++; $display("FAIL normal_check_flags: got %b expected %b", flags, 5'b11000);
        end
        tick();
        checks++;
        if ({M1dN1, BLOCK_WIDTHdN2, M1xBLOCK_WIDTHdN1xN2, M2_o} !== {16'd2, 16'd2, 16'd4, 16'd16}) begin
            errors++; $display("FAIL normal_cfg_words: got m1d=%0d bwd=%0d prod=%0d m2=%0d expected 2 2 4 16",
                               M1dN1, BLOCK_WIDTHdN2, M1xBLOCK_WIDTHdN1xN2, M2_o);
        end
        tick();
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (flags !== 5'b01000) begin
                errors++; $display("FAIL normal_run_flags[%0d]: got %b expected %b", b, flags, 5'b01000);
            end
            repeat (9) tick();
            drc = 1'b1; tick(); drc = 1'b0;
            checks++;
            if (flags !== 5'b11100) begin
                errors++; $display("FAIL normal_drain_flags[%0d]: got %b expected %b", b, flags, 5'b11100);
            end
            checks++;
            if (block_idx !== 8'(b) || b_col_base !== 12'(8 * b)) begin
                errors++; $display("FAIL normal_block_pos[%0d]: got idx=%0d base=%0d expected idx=%0d base=%0d",
                                   b, block_idx, b_col_base, b, 8 * b);
            end
            tick();
            ack = 1'b1; tick(); ack = 1'b0;
            checks++;
            if (flags !== 5'b11000) begin
                errors++; $display("FAIL normal_next_flags[%0d]: got %b expected %b", b, flags, 5'b11000);
            end
            tick();
            if (b < 2) begin
                checks++;
                if (flags !== 5'b11000 || block_idx !== 8'(b + 1)) begin
                    errors++; $display("FAIL normal_cfg_advance[%0d]: got flags=%b idx=%0d expected flags=11000 idx=%0d",
                                       b, flags, block_idx, b + 1);
                end
                tick();
            end else begin
                checks++;
                if (flags !== 5'b11010) begin
                    errors++; $display("FAIL normal_fin_flags: got %b expected %b", flags, 5'b11010);
                end
                tick();
                checks++;
                if (flags !== 5'b10000) begin
                    errors++; $display("FAIL normal_idle_flags: got %b expected %b", flags, 5'b10000);
                end
            end
        end
        checks++;
        if (done_count - d0 !== 1) begin
            errors++; $display("FAIL normal_done_pulses: got %0d expected 1", done_count - d0);
        end
    endtask

    task automatic test_bad_m1();
        int d0;
        d0 = done_count;
        start_job(6, 16, 8, 3);
        checks++;
        if (flags !== 5'b11000) begin
            errors++; $display("FAIL bad_m1_check_flags: got %b expected %b", flags, 5'b11000);
        end
        tick();
        checks++;
        if (flags !== 5'b10001) begin
            errors++; $display("FAIL bad_m1_reject_flags: got %b expected %b", flags, 5'b10001);
        end
        repeat (3) tick();
        checks++;
        if (flags !== 5'b10001 || done_count !== d0) begin
            errors++; $display("FAIL bad_m1_sticky: got flags=%b dones=%0d expected flags=10001 dones=%0d",
                               flags, done_count, d0);
        end
    endtask

    task automatic test_backpressure();
        start_job(8, 16, 8, 2);
        checks++;
        if (flags !== 5'b11000) begin
            errors++; $display("FAIL bp_err_cleared: got %b expected %b", flags, 5'b11000);
        end
        tick(); tick();
        drc = 1'b1; tick(); drc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (flags !== 5'b11100 || block_idx !== 8'd0) begin
                errors++; $display("FAIL bp_hold[%0d]: got flags=%b idx=%0d expected flags=11100 idx=0",
                                   i, flags, block_idx);
            end
            tick();
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (flags !== 5'b11000) begin
            errors++; $display("FAIL bp_release_flags: got %b expected %b", flags, 5'b11000);
        end
        tick();
        checks++;
        if (block_idx !== 8'd1 || b_col_base !== 12'd8) begin
            errors++; $display("FAIL bp_advance: got idx=%0d base=%0d expected idx=1 base=8", block_idx, b_col_base);
        end
        tick();
        drc = 1'b1; tick(); drc = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        tick();
        checks++;
        if (flags !== 5'b11010) begin
            errors++; $display("FAIL bp_fin_flags: got %b expected %b", flags, 5'b11010);
        end
        tick();
    endtask

    task automatic test_reject_table();
        logic [4:0] exp;
        for (int i = 0; i < 9; i++) begin
            start_job(tab_m1[i], tab_m2[i], tab_bw[i], tab_nb[i]);
            tick();
            exp = tab_rej[i] ? 5'b10001 : 5'b11000;
            checks++;
            if (flags !== exp) begin
                errors++; $display("FAIL reject_table[%0d]: got flags=%b expected %b", i, flags, exp);
            end
            if (!tab_rej[i]) begin
                abort = 1'b1; tick(); abort = 1'b0;
            end else begin
                tick();
            end
        end
        checks++;
        if (flags !== 5'b10000) begin
            errors++; $display("FAIL reject_table_abort_cfg: got %b expected %b", flags, 5'b10000);
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_count;
        // Abort and ack together in DRAIN: abort must win.
        start_job(8, 16, 8, 3);
        tick(); tick();
        drc = 1'b1; tick(); drc = 1'b0;
        abort = 1'b1; ack = 1'b1; tick(); abort = 1'b0; ack = 1'b0;
        checks++;
        if (flags !== 5'b10000) begin
            errors++; $display("FAIL abort_over_ack: got %b expected %b", flags, 5'b10000);
        end
        // Abort mid-RUN of block 1.
        start_job(8, 16, 8, 3);
        tick(); tick();
        drc = 1'b1; tick(); drc = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        tick(); tick();
        repeat (3) tick();
        checks++;
        if (flags !== 5'b01000 || block_idx !== 8'd1) begin
            errors++; $display("FAIL abort_pre_run: got flags=%b idx=%0d expected flags=01000 idx=1", flags, block_idx);
        end
        abort = 1'b1; tick(); abort = 1'b0;
        checks++;
        if (flags !== 5'b10000 || done_count !== d0) begin
            errors++; $display("FAIL abort_mid_run: got flags=%b dones=%0d expected flags=10000 dones=%0d",
                               flags, done_count, d0);
        end
        start_job(8, 16, 8, 2);
        tick();
        checks++;
        if (block_idx !== 8'd0 || b_col_base !== 12'd0) begin
            errors++; $display("FAIL abort_restart_pos: got idx=%0d base=%0d expected 0 0", block_idx, b_col_base);
        end
        tick();
        for (int b = 0; b < 2; b++) begin
            drc = 1'b1; tick(); drc = 1'b0;
            ack = 1'b1; tick(); ack = 1'b0;
            tick();
            if (b == 0) tick();
        end
        checks++;
        if (flags !== 5'b11010 || block_idx !== 8'd1 || b_col_base !== 12'd8) begin
            errors++; $display("FAIL abort_restart_fin: got flags=%b idx=%0d base=%0d expected flags=11010 idx=1 base=8",
                               flags, block_idx, b_col_base);
        end
        tick();
        checks++;
        if (done_count - d0 !== 1) begin
            errors++; $display("FAIL abort_restart_done: got %0d expected 1", done_count - d0);
        end
    endtask

    task automatic test_start_ignored();
        start_job(8, 16, 8, 1);
        tick(); tick();
        m1 = 16'd16; m2 = 16'd32; bw = 16'd16; nb = 8'd4;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (flags !== 5'b01000) begin
            errors++; $display("FAIL ignore_start_flags: got %b expected %b", flags, 5'b01000);
        end
        checks++;
        if ({M1dN1, BLOCK_WIDTHdN2, M1xBLOCK_WIDTHdN1xN2, M2_o} !== {16'd2, 16'd2, 16'd4, 16'd16}) begin
            errors++; $display("FAIL ignore_start_cfg: got m1d=%0d bwd=%0d prod=%0d m2=%0d expected 2 2 4 16",
                               M1dN1, BLOCK_WIDTHdN2, M1xBLOCK_WIDTHdN1xN2, M2_o);
        end
        drc = 1'b1; tick(); drc = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        tick();
        checks++;
        if (flags !== 5'b11010) begin
            errors++; $display("FAIL ignore_start_fin: got %b expected %b", flags, 5'b11010);
        end
        tick();
    endtask

    task automatic test_async_reset();
        start_job(8, 16, 8, 2);
        tick(); tick();
        drc = 1'b1; tick(); drc = 1'b0;
        checks++;
        if (flags !== 5'b11100) begin
            errors++; $display("FAIL areset_pre_drain: got %b expected %b", flags, 5'b11100);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (flags !== 5'b10000) begin
            errors++; $display("FAIL areset_flags: got %b expected %b", flags, 5'b10000);
        end
        checks++;
        if ({block_idx, b_col_base, M2_o, M1dN1, BLOCK_WIDTHdN2, M1xBLOCK_WIDTHdN1xN2} !== 84'd0) begin
            errors++; $display("FAIL areset_words: got idx=%0d base=%0d m2=%0d m1d=%0d bwd=%0d prod=%0d expected all 0",
                               block_idx, b_col_base, M2_o, M1dN1, BLOCK_WIDTHdN2, M1xBLOCK_WIDTHdN1xN2);
        end
        #2 rst = 1'b0;
        tick();
        ack = 1'b1; drc = 1'b1; tick(); ack = 1'b0; drc = 1'b0;
        tick();
        checks++;
        if (flags !== 5'b10000) begin
            errors++; $display("FAIL areset_idle_after: got %b expected %b", flags, 5'b10000);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        m1 = '0; m2 = '0; bw = '0; nb = '0; drc = 1'b0; ack = 1'b0;
        test_reset();
        test_normal();
        test_bad_m1();
        test_backpressure();
        test_reject_table();
        test_abort();
        test_start_ignored();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
